// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back scheduler.
// Optional build macro: WB_R0_DISCARD_EN -- register writes to r0 are dropped.
package wb_pkg;

  localparam int DW  = 16;
  localparam int RAW = 5;
  localparam int MAW = 8;

  // The state names the write currently driven on the output ports.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REG1 = 2'd1,
    REG2 = 2'd2,
    MEM  = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [1:0]     reg_en;
    logic [RAW-1:0] dest1;
    logic [RAW-1:0] dest2;
    logic [DW-1:0]  data1;
    logic [DW-1:0]  data2;
    logic           mem_en;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_data;
  } wb_req_t;

  // Effective op enables {mem, reg2, reg1}; r0 writes vanish when discarding is built in.
  function automatic logic [2:0] op_enables(input wb_req_t r);
    logic [2:0] en;
    en = {r.mem_en, r.reg_en[1], r.reg_en[0]};
`ifdef WB_R0_DISCARD_EN
    if (r.dest1 == '0) en[0] = 1'b0;
    if (r.dest2 == '0) en[1] = 1'b0;
`endif
    return en;
  endfunction

endpackage

// File: rtl/wb_next_op.sv
// Combinational next-op selector: given the enabled ops and the op on the
// outputs now, pick the op that follows and flag whether the current one is last.
module wb_next_op
  import wb_pkg::*;
(
  input  logic [2:0] en_i,       // {mem, reg2, reg1}
  input  logic       dest_eq_i,  // dest1 == dest2
  input  wb_state_e  state_i,
  output wb_state_e  next_o,
  output logic       last_o
);

  logic issue_r1;

  // Walk the fixed order reg1 -> reg2 -> mem, skipping disabled ops.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_o   = IDLE;
    // A duplicate destination collapses to a single write of dest2.
    issue_r1 = en_i[0] && !(en_i[1] && dest_eq_i);
    case (state_i)
      IDLE: begin
        if (issue_r1)     next_o = REG1;
        else if (en_i[1]) next_o = REG2;
        else if (en_i[2]) next_o = MEM;
      end
      REG1: begin
        if (en_i[1])      next_o = REG2;
        else if (en_i[2]) next_o = MEM;
      end
      REG2: begin
        if (en_i[2])      next_o = MEM;
      end
      default: next_o = IDLE;
    endcase
    last_o = (next_o == IDLE);
  end

endmodule

// File: rtl/wb_scheduler.sv
// Write-back scheduler: serialises up to two register writes and one memory
// write per transaction onto single registered write ports, one per cycle.
// Optional build macro: WB_R0_DISCARD_EN (see wb_pkg::op_enables).
// The holding register uses the package widths; parameters must match them.
module wb_scheduler #(
  parameter int DW  = 16,
  parameter int RAW = 5,
  parameter int MAW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_reg_en,
  input  logic [RAW-1:0] req_dest1,
  input  logic [RAW-1:0] req_dest2,
  input  logic [DW-1:0]  req_data1,
  input  logic [DW-1:0]  req_data2,
  input  logic           req_mem_en,
  input  logic [MAW-1:0] req_mem_addr,
  input  logic [DW-1:0]  req_mem_data,
  output logic           rf_we,
  output logic [RAW-1:0] rf_waddr,
  output logic [DW-1:0]  rf_wdata,
  output logic           dm_we,
  output logic [MAW-1:0] dm_addr,
  output logic [DW-1:0]  dm_wdata,
  input  logic [RAW-1:0] chk_addr,
  output logic           chk_hit,
  output logic           busy
);

  import wb_pkg::*;

  wb_req_t        in_req, hold_q, hold_d;
  wb_state_e      state_q, state_d, adv_next, acc_first;
  logic [2:0]     hold_en, in_en;
  logic           adv_last, acc_last_unused, accept;
  logic           rf_we_q, rf_we_d, dm_we_q, dm_we_d, busy_q;
  logic [RAW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]  rf_wdata_q, rf_wdata_d, dm_wdata_q, dm_wdata_d;
  logic [MAW-1:0] dm_addr_q, dm_addr_d;

  // Pack the incoming payload into the holding-register layout.
  always_comb begin
    in_req.reg_en   = req_reg_en;
    in_req.dest1    = req_dest1;
    in_req.dest2    = req_dest2;
    in_req.data1    = req_data1;
    in_req.data2    = req_data2;
    in_req.mem_en   = req_mem_en;
    in_req.mem_addr = req_mem_addr;
    in_req.mem_data = req_mem_data;
  end

  assign hold_en = op_enables(hold_q);
  assign in_en   = op_enables(in_req);

  // Advance path: what follows the op currently on the outputs.
  wb_next_op u_adv (
    .en_i      (hold_en),
    .dest_eq_i (hold_q.dest1 == hold_q.dest2),
    .state_i   (state_q),
    .next_o    (adv_next),
    .last_o    (adv_last)
  );

  // Accept path: first op of the incoming transaction.
  wb_next_op u_acc (
    .en_i      (in_en),
    .dest_eq_i (req_dest1 == req_dest2),
    .state_i   (IDLE),
    .next_o    (acc_first),
    .last_o    (acc_last_unused)
  );

  // A new transaction is taken on the last-op cycle for zero-bubble chaining.
  assign req_ready = !rst && ((state_q == IDLE) || adv_last);
  assign accept    = req_valid && req_ready;

  // Next state, holding register and next values of the registered write ports.
  always_comb begin
    hold_d     = hold_q;
    state_d    = state_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    if (accept) begin
      hold_d  = in_req;
      state_d = acc_first;
    end else if (state_q != IDLE) begin
      state_d = adv_next;
    end
    rf_we_d = (state_d == REG1) || (state_d == REG2);
    dm_we_d = (state_d == MEM);
    if (state_d == REG1) begin
      rf_waddr_d = hold_d.dest1;
      rf_wdata_d = hold_d.data1;
    end else if (state_d == REG2) begin
      rf_waddr_d = hold_d.dest2;
      rf_wdata_d = hold_d.data2;
    end
    if (state_d == MEM) begin
      dm_addr_d  = hold_d.mem_addr;
      dm_wdata_d = hold_d.mem_data;
    end
  end

  // State, holding register and output port registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  // Hazard check: destinations of the driven op and any op still to come.
  always_comb begin
    chk_hit = 1'b0;
    case (state_q)
      REG1: chk_hit = (hold_en[0] && (hold_q.dest1 == chk_addr)) ||
                      (hold_en[1] && (hold_q.dest2 == chk_addr));
      REG2: chk_hit = (hold_q.dest2 == chk_addr);
      default: chk_hit = 1'b0;
    endcase
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed self-checking bench for wb_scheduler.
// Expected r0 behaviour follows the WB_R0_DISCARD_EN build macro.
module tb_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_reg_en = 2'b00;
  logic [4:0]  req_dest1 = '0, req_dest2 = '0;
  logic [15:0] req_data1 = '0, req_data2 = '0;
  logic        req_mem_en = 1'b0;
  logic [7:0]  req_mem_addr = '0;
  logic [15:0] req_mem_data = '0;
  logic        rf_we, dm_we, chk_hit, busy;
  logic [4:0]  rf_waddr;
  logic [15:0] rf_wdata, dm_wdata;
  logic [7:0]  dm_addr;
  logic [4:0]  chk_addr = '0;

  int checks = 0;
  int errors = 0;

`ifdef WB_R0_DISCARD_EN
  localparam logic R0_DISC = 1'b1;
`else
  localparam logic R0_DISC = 1'b0;
`endif

  wb_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg_en(req_reg_en),
    .req_dest1(req_dest1), .req_dest2(req_dest2),
    .req_data1(req_data1), .req_data2(req_data2),
    .req_mem_en(req_mem_en), .req_mem_addr(req_mem_addr), .req_mem_data(req_mem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] en, input logic [4:0] d1, input logic [15:0] x1,
                       input logic [4:0] d2, input logic [15:0] x2,
                       input logic me, input logic [7:0] ma, input logic [15:0] md);
    req_valid = 1'b1;
    req_reg_en = en; req_dest1 = d1; req_data1 = x1; req_dest2 = d2; req_data2 = x2;
    req_mem_en = me; req_mem_addr = ma; req_mem_data = md;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_ready", req_ready, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_dm_we", dm_we, 0);
    check("rst_busy", busy, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_dm_addr", dm_addr, 0);
    rst = 1'b0; #1;
    check("idle_ready", req_ready, 1);

    // Three-op transaction
    offer(2'b11, 5'd3, 16'h1111, 5'd7, 16'h2222, 1'b1, 8'h40, 16'hBEEF);
    tick(); req_valid = 1'b0;
    check("t1_r1_we", rf_we, 1);
    check("t1_r1_addr", rf_waddr, 3);
    check("t1_r1_data", rf_wdata, 16'h1111);
    check("t1_r1_dmwe", dm_we, 0);
    check("t1_r1_ready", req_ready, 0);
    check("t1_r1_busy", busy, 1);
    chk_addr = 5'd7; #1;
    check("t1_chk7", chk_hit, 1);
    chk_addr = 5'd3; #1;
    check("t1_chk3_cur", chk_hit, 1);
    tick();
    check("t1_r2_addr", rf_waddr, 7);
    check("t1_r2_data", rf_wdata, 16'h2222);
    check("t1_r2_ready", req_ready, 0);
    check("t1_chk3_done", chk_hit, 0);
    tick();
    check("t1_m_we", dm_we, 1);
    check("t1_m_rfwe", rf_we, 0);
    check("t1_m_addr", dm_addr, 8'h40);
    check("t1_m_data", dm_wdata, 16'hBEEF);
    check("t1_m_ready", req_ready, 1);
    check("t1_m_hold_waddr", rf_waddr, 7);
    tick();
    check("t1_end_dmwe", dm_we, 0);
    check("t1_end_busy", busy, 0);
    check("t1_end_hold_addr", dm_addr, 8'h40);

    // Back-to-back single-dest transactions
    offer(2'b01, 5'd1, 16'h0001, 5'd0, 16'h0000, 1'b0, 8'h00, 16'h0000);
    check("b2b_ready0", req_ready, 1);
    tick();
    check("b2b_a_we", rf_we, 1);
    check("b2b_a_addr", rf_waddr, 1);
    check("b2b_a_data", rf_wdata, 16'h0001);
    check("b2b_a_ready", req_ready, 1);
    offer(2'b01, 5'd2, 16'h0002, 5'd0, 16'h0000, 1'b0, 8'h00, 16'h0000);
    tick(); req_valid = 1'b0;
    check("b2b_b_we", rf_we, 1);
    check("b2b_b_addr", rf_waddr, 2);
    check("b2b_b_data", rf_wdata, 16'h0002);
    check("b2b_b_ready", req_ready, 1);
    tick();
    check("b2b_end_we", rf_we, 0);

    // Duplicate destination: single write of data2
    offer(2'b11, 5'd5, 16'hAAAA, 5'd5, 16'h5555, 1'b0, 8'h00, 16'h0000);
    tick(); req_valid = 1'b0;
    check("dup_we", rf_we, 1);
    check("dup_addr", rf_waddr, 5);
    check("dup_data", rf_wdata, 16'h5555);
    check("dup_ready", req_ready, 1);
    tick();
    check("dup_end_we", rf_we, 0);
    check("dup_end_busy", busy, 0);

    // Hazard check across a 3-op transaction
    offer(2'b11, 5'd4, 16'h0444, 5'd9, 16'h0999, 1'b1, 8'h7F, 16'h1234);
    tick(); req_valid = 1'b0;
    chk_addr = 5'd9; #1;
    check("chk_reg1_9", chk_hit, 1);
    chk_addr = 5'd2; #1;
    check("chk_reg1_2", chk_hit, 0);
    chk_addr = 5'd9;
    tick();
    check("chk_reg2_9", chk_hit, 1);
    tick();
    check("chk_mem_9", chk_hit, 0);
    check("chk_mem_addr", dm_addr, 8'h7F);
    tick();
    check("chk_idle_9", chk_hit, 0);

    // Reset during REG2
    offer(2'b11, 5'd4, 16'h0444, 5'd9, 16'h0999, 1'b1, 8'h22, 16'h7777);
    tick(); req_valid = 1'b0;
    tick();
    check("mrst_in_reg2", rf_waddr, 9);
    rst = 1'b1; #1;
    check("mrst_ready_low", req_ready, 0);
    tick();
    check("mrst_rf_we", rf_we, 0);
    check("mrst_dm_we", dm_we, 0);
    check("mrst_waddr", rf_waddr, 0);
    check("mrst_wdata", rf_wdata, 0);
    check("mrst_dm_addr", dm_addr, 0);
    check("mrst_dm_data", dm_wdata, 0);
    check("mrst_busy", busy, 0);
    rst = 1'b0; #1;
    check("mrst_ready_rise", req_ready, 1);
    tick();
    check("mrst_no_mem", dm_we, 0);
    check("mrst_no_mem_addr", dm_addr, 0);

    // Empty transaction retires immediately
    offer(2'b00, 5'd6, 16'h0006, 5'd6, 16'h0006, 1'b0, 8'h11, 16'h0011);
    tick(); req_valid = 1'b0;
    check("empty_busy", busy, 0);
    check("empty_rf_we", rf_we, 0);
    check("empty_dm_we", dm_we, 0);
    check("empty_ready", req_ready, 1);

    // Memory-only transaction
    offer(2'b00, 5'd0, 16'h0000, 5'd0, 16'h0000, 1'b1, 8'hFF, 16'hFFFF);
    tick(); req_valid = 1'b0;
    check("memonly_we", dm_we, 1);
    check("memonly_rfwe", rf_we, 0);
    check("memonly_addr", dm_addr, 8'hFF);
    check("memonly_data", dm_wdata, 16'hFFFF);
    tick();

    // Register 0 destination
    offer(2'b01, 5'd0, 16'hCAFE, 5'd0, 16'h0000, 1'b0, 8'h00, 16'h0000);
    tick(); req_valid = 1'b0;
    chk_addr = 5'd0; #1;
    check("r0_we", rf_we, {31'd0, !R0_DISC});
    check("r0_busy", busy, {31'd0, !R0_DISC});
    check("r0_chk", chk_hit, {31'd0, !R0_DISC});
    check("r0_ready", req_ready, 1);
    if (!R0_DISC) begin
      check("r0_addr", rf_waddr, 0);
      check("r0_data", rf_wdata, 16'hCAFE);
    end
    tick();
    check("r0_end_we", rf_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_scheduler.md
# wb_scheduler

Write-back scheduler for the 16-bit Harvard core. It sits between the execute stage and the register file / data memory. It accepts one write-back transaction per handshake, carrying up to two register writes and one memory write. It serialises these onto the single register-file write port and the data-memory write port, one write per cycle, and reports pending destinations to decode for stall decisions.

## Interface
Parameters:
- DW, 16, data width
- RAW, 5, register address width
- MAW, 8, data-memory address width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  transaction offered
- req_ready  out  1  scheduler accepts this cycle
- req_reg_en  in  2  bit0 = dest1 write, bit1 = dest2 write
- req_dest1, req_dest2  in  RAW  register destinations
- req_data1, req_data2  in  DW  register write data
- req_mem_en  in  1  memory write requested
- req_mem_addr  in  MAW  memory address
- req_mem_data  in  DW  memory write data
- rf_we / rf_waddr / rf_wdata  out  1/RAW/DW  registered register-file write port
- dm_we / dm_addr / dm_wdata  out  1/MAW/DW  registered data-memory write port
- chk_addr  in  RAW  decode source register to check
- chk_hit  out  1  combinational: chk_addr matches a not-yet-issued register write
- busy  out  1  registered: state != IDLE

## Operation
- States: IDLE, REG1, REG2, MEM. The state names the write currently driven on the outputs.
- Accept = req_valid && req_ready. The transaction is latched into a one-entry holding register.
- Issue order is fixed: dest1, then dest2, then mem. Disabled ops are skipped, with no bubble cycles.
- If both reg enables are set and dest1 == dest2, only REG2 is issued, with data2 (dest2 wins). This saves one cycle.
- A transaction with no enables is accepted and retired immediately. No write occurs and the state stays IDLE.
- req_ready = !rst && (state == IDLE || current op is the last op of the held transaction). A new transaction is therefore accepted on the last-op cycle. Its first op drives the outputs in the next cycle, giving zero-bubble back-to-back operation.
- In REG1/REG2: rf_we = 1, dm_we = 0. In MEM: dm_we = 1, rf_we = 0. In IDLE: both are 0. Address and data outputs hold their last value when the enable is low.
- chk_hit is high when chk_addr equals the dest of any held op not yet driven, or of the op driven this cycle. It is 0 in IDLE.
- Widths are pass-through; there is no arithmetic. The mem address is used as given; no shifting or extension is done here.

## Timing
- Reset: state = IDLE; rf_we, dm_we, busy and req_ready = 0; rf_waddr, rf_wdata, dm_addr, dm_wdata = 0; holding register cleared.
- Reset mid-transaction: unissued writes are discarded, and the enables are 0 from the first edge at which rst is sampled high.
- Latency: accept at edge N means the first write is on the outputs during cycle N+1. A transaction with k ops occupies k cycles.
- req_valid held while req_ready = 0: the payload must stay stable. The scheduler never drops or duplicates an op.

## Configuration
- WB_R0_DISCARD_EN defined: any register op with dest == 0 is treated as disabled. It is skipped, and chk_hit never fires for address 0.
- Macro undefined: register 0 is an ordinary writable destination.

## Structure
- Package wb_pkg holds:
  - the state enum (IDLE/REG1/REG2/MEM);
  - the default width constants DW/RAW/MAW;
  - a packed wb_req_t struct (enables, dests, data, mem fields) used for the holding register.
- One sub-module, wb_next_op: a combinational next-op selector. It takes the held enables, the dest-equality flag and the current state, and returns the next state plus a last-op flag. It is shared by the accept path and the advance path.

## Test plan
- Reset, then req with reg_en = 11, dest1 = 3/data 0x1111, dest2 = 7/data 0x2222, mem_en = 1, addr 0x40/data 0xBEEF. Required: rf writes r3 = 0x1111, then r7 = 0x2222, then dm[0x40] = 0xBEEF on consecutive cycles; req_ready low for the first two of these cycles.
- Back-to-back: two single-dest requests (r1 = 0x0001, r2 = 0x0002) with req_valid held. Required: rf_we high on two consecutive cycles and req_ready high on every cycle.
- reg_en = 11, dest1 = dest2 = 5, data 0xAAAA/0x5555. Required: exactly one write, r5 = 0x5555, lasting 1 cycle.
- During REG1 of a 3-op transaction with dest2 = 9, chk_addr = 9 → chk_hit = 1. After REG2 issues, chk_addr = 9 → chk_hit = 0.
- rst asserted during REG2. Required: no MEM write ever occurs; all outputs are 0 on the next cycle; req_ready rises the cycle after rst falls.
- With WB_R0_DISCARD_EN defined: reg_en = 01, dest1 = 0 → no rf_we and immediate retire. Without the macro: r0 is written.
